// File: rtl/norm3_rr_arbiter_if.sv
// rtl/norm3_rr_arbiter_if.sv - request, normalizer and response bundle for norm3_rr_arbiter
interface norm3_rr_arbiter_if #(
  parameter int FRAC_BITS = 32,
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*FRAC_BITS-1:0] req_x;
  logic [NUM_REQ*FRAC_BITS-1:0] req_y;
  logic [NUM_REQ*FRAC_BITS-1:0] req_z;

  logic                 nrm_in_valid;
  logic [FRAC_BITS-1:0] nrm_in_x;
  logic [FRAC_BITS-1:0] nrm_in_y;
  logic [FRAC_BITS-1:0] nrm_in_z;

  logic                 nrm_out_valid;
  logic [FRAC_BITS-1:0] nrm_out_x;
  logic [FRAC_BITS-1:0] nrm_out_y;
  logic [FRAC_BITS-1:0] nrm_out_z;

  logic [NUM_REQ-1:0]   rsp_valid;
  logic [FRAC_BITS-1:0] rsp_x;
  logic [FRAC_BITS-1:0] rsp_y;
  logic [FRAC_BITS-1:0] rsp_z;

  logic [CNT_W-1:0] outstanding;
  logic             err_orphan;

  // arbiter side
  modport slave (
    input  req_valid, req_x, req_y, req_z,
    input  nrm_out_valid, nrm_out_x, nrm_out_y, nrm_out_z,
    output req_ready,
    output nrm_in_valid, nrm_in_x, nrm_in_y, nrm_in_z,
    output rsp_valid, rsp_x, rsp_y, rsp_z,
    output outstanding, err_orphan
  );

  // requesters plus normalizer side
  modport master (
    output req_valid, req_x, req_y, req_z,
    output nrm_out_valid, nrm_out_x, nrm_out_y, nrm_out_z,
    input  req_ready,
    input  nrm_in_valid, nrm_in_x, nrm_in_y, nrm_in_z,
    input  rsp_valid, rsp_x, rsp_y, rsp_z,
    input  outstanding, err_orphan
  );
endinterface

// File: rtl/norm3_rr_arbiter.sv
// rtl/norm3_rr_arbiter.sv - round-robin sharing of one 3-vector normalizer; optional macro NORM3_ARB_PRIO0_EN
module norm3_rr_arbiter #(
  parameter int FRAC_BITS = 32,
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  norm3_rr_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int FP_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TAG_DEPTH);
  localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(TAG_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] NREQ_C   = IDX_W'(NUM_REQ);

  // registered state
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [FP_W-1:0]      wr_q, wr_d;
  logic [FP_W-1:0]      rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 nrm_in_valid_q, nrm_in_valid_d;
  logic [FRAC_BITS-1:0] nrm_in_x_q, nrm_in_x_d;
  logic [FRAC_BITS-1:0] nrm_in_y_q, nrm_in_y_d;
  logic [FRAC_BITS-1:0] nrm_in_z_q, nrm_in_z_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [FRAC_BITS-1:0] rsp_x_q, rsp_x_d;
  logic [FRAC_BITS-1:0] rsp_y_q, rsp_y_d;
  logic [FRAC_BITS-1:0] rsp_z_q, rsp_z_d;
  logic                 err_orphan_q, err_orphan_d;
  logic [PTR_W-1:0]     tag_mem_q [TAG_DEPTH];

  // combinational
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [IDX_W-1:0]   idx_w;
  logic               credit_ok;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               push;
  logic               pop;
  logic               empty;
  logic [PTR_W-1:0]   pop_tag;

  // credit uses the registered count, so a pop never opens a grant in its own cycle
  assign credit_ok = (cnt_q < DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign pop       = bus.nrm_out_valid & ~empty;
  assign pop_tag   = tag_mem_q[rd_q];

  // pick the first valid requester at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
`ifdef NORM3_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + IDX_W'(k);
      if (idx_w >= NREQ_C) idx_w = idx_w - NREQ_C;
      if (!found && bus.req_valid[idx_w[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx_w[PTR_W-1:0];
      end
    end
  end

  // one-hot grant, withheld without credit and while reset is asserted
  always_comb begin
    req_ready_c = '0;
    if (found && credit_ok && rst_n) req_ready_c[win] = 1'b1;
  end

  assign push          = |req_ready_c;
  assign bus.req_ready = req_ready_c;

  // next-state for pointer, tag FIFO, issue register and response register
  always_comb begin
    ptr_d          = ptr_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    nrm_in_valid_d = push;
    nrm_in_x_d     = nrm_in_x_q;
    nrm_in_y_d     = nrm_in_y_q;
    nrm_in_z_d     = nrm_in_z_q;
    rsp_valid_d    = '0;
    rsp_x_d        = rsp_x_q;
    rsp_y_d        = rsp_y_q;
    rsp_z_d        = rsp_z_q;
    err_orphan_d   = err_orphan_q;

    if (push) begin
`ifdef NORM3_ARB_PRIO0_EN
      // a requester-0 win leaves the rotation among the others untouched
      if (win != '0) ptr_d = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
`else
      ptr_d = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
`endif
      wr_d       = (wr_q == FP_LAST) ? '0 : wr_q + FP_W'(1);
      nrm_in_x_d = bus.req_x[win*FRAC_BITS +: FRAC_BITS];
      nrm_in_y_d = bus.req_y[win*FRAC_BITS +: FRAC_BITS];
      nrm_in_z_d = bus.req_z[win*FRAC_BITS +: FRAC_BITS];
    end

    if (pop) begin
      rd_d                 = (rd_q == FP_LAST) ? '0 : rd_q + FP_W'(1);
      rsp_valid_d[pop_tag] = 1'b1;
      rsp_x_d              = bus.nrm_out_x;
      rsp_y_d              = bus.nrm_out_y;
      rsp_z_d              = bus.nrm_out_z;
    end

    // a result with no tag to route it is dropped and flagged until reset
    if (bus.nrm_out_valid && empty) err_orphan_d = 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      nrm_in_valid_q <= 1'b0;
      nrm_in_x_q     <= '0;
      nrm_in_y_q     <= '0;
      nrm_in_z_q     <= '0;
      rsp_valid_q    <= '0;
      rsp_x_q        <= '0;
      rsp_y_q        <= '0;
      rsp_z_q        <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      nrm_in_valid_q <= nrm_in_valid_d;
      nrm_in_x_q     <= nrm_in_x_d;
      nrm_in_y_q     <= nrm_in_y_d;
      nrm_in_z_q     <= nrm_in_z_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_x_q        <= rsp_x_d;
      rsp_y_q        <= rsp_y_d;
      rsp_z_q        <= rsp_z_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  // tag storage needs no reset: the count decides which entries are live
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_q] <= win;
  end

  assign bus.nrm_in_valid = nrm_in_valid_q;
  assign bus.nrm_in_x     = nrm_in_x_q;
  assign bus.nrm_in_y     = nrm_in_y_q;
  assign bus.nrm_in_z     = nrm_in_z_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_x        = rsp_x_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_z        = rsp_z_q;
  assign bus.outstanding  = cnt_q;
  assign bus.err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_norm3_rr_arbiter.sv
// tb/tb_norm3_rr_arbiter.sv - scoreboard bench for norm3_rr_arbiter with latency-12 XOR-1 normalizer stub
module tb_norm3_rr_arbiter;
  localparam int FB   = 32;
  localparam int NR   = 4;
  localparam int TD_A = 16;
  localparam int TD_B = 4;
  localparam int LAT  = 12;

  typedef struct { int idx; int cyc; } gnt_t;
  typedef struct { logic [NR-1:0] oh; logic [FB-1:0] x; logic [FB-1:0] y; logic [FB-1:0] z; int hs; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  gnt_t exp_grant[$];
  rsp_t exp_rsp[$];

  logic          inj_v = 1'b0;
  logic [FB-1:0] inj_x = 32'h1357_2468;

  int nin_cnt = 0, nin_cur = 0, nin_run = 0;
  int b_grants = 0, b_peak = 0;
  logic b_seen = 1'b0, b_mon_en = 1'b0;
  logic [NR-1:0] b_first_oh = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  norm3_rr_arbiter_if #(.FRAC_BITS(FB), .NUM_REQ(NR), .TAG_DEPTH(TD_A)) bus_a ();
  norm3_rr_arbiter_if #(.FRAC_BITS(FB), .NUM_REQ(NR), .TAG_DEPTH(TD_B)) bus_b ();

  norm3_rr_arbiter #(.FRAC_BITS(FB), .NUM_REQ(NR), .TAG_DEPTH(TD_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  norm3_rr_arbiter #(.FRAC_BITS(FB), .NUM_REQ(NR), .TAG_DEPTH(TD_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // normalizer stubs: LAT-stage pipeline, each component XOR 1
  logic          pa_v [LAT];
  logic [3*FB-1:0] pa_d [LAT];
  logic          pb_v [LAT];
  logic [3*FB-1:0] pb_d [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin pa_v[i] <= 1'b0; pb_v[i] <= 1'b0; end
    end else begin
      pa_v[0] <= bus_a.nrm_in_valid;
      pa_d[0] <= {bus_a.nrm_in_x ^ 32'h1, bus_a.nrm_in_y ^ 32'h1, bus_a.nrm_in_z ^ 32'h1};
      pb_v[0] <= bus_b.nrm_in_valid;
      pb_d[0] <= {bus_b.nrm_in_x ^ 32'h1, bus_b.nrm_in_y ^ 32'h1, bus_b.nrm_in_z ^ 32'h1};
      for (int i = 1; i < LAT; i++) begin
        pa_v[i] <= pa_v[i-1]; pa_d[i] <= pa_d[i-1];
        pb_v[i] <= pb_v[i-1]; pb_d[i] <= pb_d[i-1];
      end
    end
  end

  assign bus_a.nrm_out_valid = pa_v[LAT-1] | inj_v;
  assign bus_a.nrm_out_x     = inj_v ? inj_x : pa_d[LAT-1][3*FB-1:2*FB];
  assign bus_a.nrm_out_y     = inj_v ? inj_x : pa_d[LAT-1][2*FB-1:FB];
  assign bus_a.nrm_out_z     = inj_v ? inj_x : pa_d[LAT-1][FB-1:0];
  assign bus_b.nrm_out_valid = pb_v[LAT-1];
  assign bus_b.nrm_out_x     = pb_d[LAT-1][3*FB-1:2*FB];
  assign bus_b.nrm_out_y     = pb_d[LAT-1][2*FB-1:FB];
  assign bus_b.nrm_out_z     = pb_d[LAT-1][FB-1:0];

  function automatic logic [FB-1:0] xv(input int i, input int k);
    return {8'(i + 1), 8'(k), 16'h4C00};
  endfunction
  function automatic logic [FB-1:0] yv(input int i, input int k);
    return xv(i, k) ^ 32'hFFFF_0000;
  endfunction
  function automatic logic [FB-1:0] zv(input int i, input int k);
    return xv(i, k) ^ 32'h00FF_FF00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k);
    for (int i = 0; i < NR; i++) begin
      bus_a.req_x[i*FB +: FB] = xv(i, k);
      bus_a.req_y[i*FB +: FB] = yv(i, k);
      bus_a.req_z[i*FB +: FB] = zv(i, k);
    end
  endtask

  task automatic expect_grant(input int g, input int k);
    exp_grant.push_back('{idx: g, cyc: cyc});
    exp_rsp.push_back('{oh: NR'(1 << g), x: xv(g, k) ^ 32'h1, y: yv(g, k) ^ 32'h1,
                        z: zv(g, k) ^ 32'h1, hs: cyc});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_rsp.size() != 0) && n < 80) begin
      tick();
      n++;
    end
    chk({nm, "_drain"}, 64'(exp_grant.size() + exp_rsp.size()), 64'd0);
    exp_grant.delete();
    exp_rsp.delete();
  endtask

  task automatic do_reset();
    bus_a.req_valid = '0;
    bus_b.req_valid = '0;
    inj_v = 1'b0;
    rst_n = 1'b0;
    exp_grant.delete();
    exp_rsp.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(bus_a.req_ready), 64'd0);
    chk({nm, "_nrm_in_valid"}, 64'(bus_a.nrm_in_valid), 64'd0);
    chk({nm, "_nrm_in_x"}, 64'(bus_a.nrm_in_x), 64'd0);
    chk({nm, "_rsp_valid"}, 64'(bus_a.rsp_valid), 64'd0);
    chk({nm, "_rsp_x"}, 64'(bus_a.rsp_x), 64'd0);
    chk({nm, "_outstanding"}, 64'(bus_a.outstanding), 64'd0);
    chk({nm, "_err_orphan"}, 64'(bus_a.err_orphan), 64'd0);
  endtask

  // monitor for instance A: grants and responses are popped from the scoreboard as they appear
  always @(negedge clk) begin
    logic [NR-1:0] hs;
    gnt_t g;
    rsp_t r;
    if (rst_n) begin
      hs = bus_a.req_valid & bus_a.req_ready;
      chk("ready_onehot0", 64'($onehot0(bus_a.req_ready)), 64'd1);
      if (hs != '0) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 64'(hs), 64'd0);
        else begin
          g = exp_grant.pop_front();
          chk("grant_idx", 64'(hs), 64'(1 << g.idx));
          chk("grant_cyc", 64'(cyc), 64'(g.cyc));
        end
      end
      if (bus_a.nrm_in_valid) begin
        nin_cnt++;
        nin_cur++;
        if (nin_cur > nin_run) nin_run = nin_cur;
      end else nin_cur = 0;
      if (bus_a.rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(bus_a.rsp_valid), 64'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(bus_a.rsp_valid), 64'(r.oh));
          chk("rsp_x", 64'(bus_a.rsp_x), 64'(r.x));
          chk("rsp_y", 64'(bus_a.rsp_y), 64'(r.y));
          chk("rsp_z", 64'(bus_a.rsp_z), 64'(r.z));
          chk("rsp_latency", 64'(cyc - r.hs), 64'd14);
        end
      end
    end
  end

  // monitor for instance B: grants before the first result and peak outstanding
  always @(negedge clk) begin
    if (rst_n && b_mon_en) begin
      if (bus_b.rsp_valid != '0 && !b_seen) begin
        b_seen = 1'b1;
        b_first_oh = bus_b.rsp_valid;
      end
      if (!b_seen && (|(bus_b.req_valid & bus_b.req_ready))) b_grants++;
      if (int'(bus_b.outstanding) > b_peak) b_peak = int'(bus_b.outstanding);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req_valid = '0; bus_a.req_x = '0; bus_a.req_y = '0; bus_a.req_z = '0;
    bus_b.req_valid = '0;
    bus_b.req_x = {NR{32'h2000_0000}}; bus_b.req_y = '0; bus_b.req_z = '0;

    // reset state, including grant suppression while reset is held
    tick();
    bus_a.req_valid = 4'hF;
    #1;
    chk_all_zero("reset");
    bus_a.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single request from requester 2
    bus_a.req_x[2*FB +: FB] = 32'h4000_0000;
    bus_a.req_y[2*FB +: FB] = '0;
    bus_a.req_z[2*FB +: FB] = '0;
    bus_a.req_valid = 4'b0100;
    exp_grant.push_back('{idx: 2, cyc: cyc});
    exp_rsp.push_back('{oh: 4'b0100, x: 32'h4000_0001, y: 32'h1, z: 32'h1, hs: cyc});
    tick();
    bus_a.req_valid = '0;
    drain("single");
    chk("single_outstanding", 64'(bus_a.outstanding), 64'd0);

    // all four valid for 8 cycles: rotation 0,1,2,3,0,1,2,3
    do_reset();
    nin_cnt = 0; nin_cur = 0; nin_run = 0;
    for (int k = 0; k < 8; k++) begin
      set_data(k);
      bus_a.req_valid = 4'hF;
      expect_grant(k % 4, k);
      tick();
    end
    bus_a.req_valid = '0;
    drain("rr4");
    chk("rr4_nin_count", 64'(nin_cnt), 64'd8);
    chk("rr4_nin_run", 64'(nin_run), 64'd8);

    // orphan result, sticky through normal traffic until reset
    do_reset();
    chk("orphan_pre", 64'(bus_a.err_orphan), 64'd0);
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    tick();
    tick();
    chk("orphan_flag", 64'(bus_a.err_orphan), 64'd1);
    chk("orphan_outstanding", 64'(bus_a.outstanding), 64'd0);
    set_data(3);
    bus_a.req_valid = 4'b0010;
    expect_grant(1, 3);
    tick();
    bus_a.req_valid = '0;
    drain("orphan_traffic");
    chk("orphan_sticky", 64'(bus_a.err_orphan), 64'd1);
    do_reset();
    chk("orphan_cleared", 64'(bus_a.err_orphan), 64'd0);

    // reset with three ops in flight
    set_data(5);
    bus_a.req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      exp_grant.push_back('{idx: k, cyc: cyc});
      tick();
    end
    bus_a.req_valid = '0;
    tick();
    chk("mid_outstanding", 64'(bus_a.outstanding), 64'd3);
    chk("mid_nrm_in_x", 64'(bus_a.nrm_in_x), 64'(xv(2, 5)));
    rst_n = 1'b0;
    bus_a.req_valid = 4'b0010;
    #1;
    chk_all_zero("mid_reset");
    exp_grant.delete();
    exp_rsp.delete();
    tick();
    tick();
    set_data(6);
    rst_n = 1'b1;
    expect_grant(1, 6);
    tick();
    bus_a.req_valid = '0;
    drain("post_reset");

    // credit limit on the depth-4 instance
    do_reset();
    b_grants = 0; b_peak = 0; b_seen = 1'b0; b_first_oh = '0; b_mon_en = 1'b1;
    bus_b.req_valid = 4'hF;
    repeat (30) tick();
    bus_b.req_valid = '0;
    repeat (30) tick();
    b_mon_en = 1'b0;
    chk("credit_grants", 64'(b_grants), 64'd4);
    chk("credit_peak", 64'(b_peak), 64'd4);
    chk("credit_seen_rsp", 64'(b_seen), 64'd1);
    chk("credit_first_rsp", 64'(b_first_oh), 64'b0001);
    chk("credit_idle", 64'(bus_b.outstanding), 64'd0);

    // requesters 0 and 3 contending, then requester 0 drops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_data(k);
      bus_a.req_valid = 4'b1001;
`ifdef NORM3_ARB_PRIO0_EN
      expect_grant(0, k);
`else
      expect_grant((k % 2 == 0) ? 0 : 3, k);
`endif
      tick();
    end
    set_data(4);
    bus_a.req_valid = 4'b1000;
    expect_grant(3, 4);
    tick();
    bus_a.req_valid = '0;
    drain("pair");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
